pattern_scan_arbiter: RTL

//  Shares one serial "110" pattern detector between two requesters.

---
 rtl/pattern_scan_arbiter.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/pattern_scan_arbiter.sv
// -----------------------------------------------------------------------------
// pattern_scan_arbiter
//
// Shares one serial "110" pattern detector between two requesters. A
// round-robin arbiter picks a requester in IDLE, and its W-bit word is
// captured in LOAD. In SCAN the word is shifted MSB-first through a
// 3-state Mealy detector. DONE then returns a per-bit match map and a
// popcount to the requester that was served.
//
// Parameters
//   W          word width in bits (>= 3)
//   CNT_W      width of match_cnt, $clog2(W+1)
//   TOT_W      width of the saturating running total (16 in normal use)
//
// Ports
//   clk        in   1       rising-edge clock
//   reset      in   1       asynchronous, active-low reset
//   req        in   2       req[i]=1: requester i wants a scan
//   word0      in   W       word from requester 0
//   word1      in   W       word from requester 1
//   gnt        out  2       one-hot grant, high from LOAD through SCAN
//   busy       out  1       high in every state except IDLE
//   done       out  2       one-cycle pulse to the served requester
//   result     out  W       match map: bit k set iff bits k+2,k+1,k = 1,1,0
//   match_cnt  out  CNT_W   popcount of result
//   total_cnt  out  TOT_W   matches since reset, saturating at all-ones
// -----------------------------------------------------------------------------
module pattern_scan_arbiter #(
    parameter int unsigned W     = 16,
    parameter int unsigned CNT_W = $clog2(W + 1),
    parameter int unsigned TOT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [W-1:0]     word0,
    input  logic [W-1:0]     word1,
    output logic [1:0]       gnt,
    output logic             busy,
    output logic [1:0]       done,
    output logic [W-1:0]     result,
    output logic [CNT_W-1:0] match_cnt,
    output logic [TOT_W-1:0] total_cnt
);

    localparam int unsigned IDX_W = $clog2(W);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(W - 1);

    // Control FSM
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_SCAN = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Detector: number of consecutive 1s seen so far (0, 1, >=2)
    localparam logic [1:0] DET_S0 = 2'd0;
    localparam logic [1:0] DET_S1 = 2'd1;
    localparam logic [1:0] DET_S2 = 2'd2;

    logic [1:0]       state;
    logic             sel;        // requester being served
    logic             last;       // requester served most recently
    logic             pick;       // arbitration result for this IDLE cycle
    logic [W-1:0]     shreg;      // captured word
    logic [W-1:0]     map;        // match map under construction
    logic [W-1:0]     map_nxt;
    logic [1:0]       det;
    logic [1:0]       det_nxt;
    logic             cur_bit;
    logic             hit;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] cnt_nxt;
    logic [TOT_W:0]   tot_sum;

    // ------------------------------------------------------------------
    // Round-robin pick: a lone request always wins; with both pending the
    // requester that was not served last wins.
    // ------------------------------------------------------------------
    always_comb begin
        pick = 1'b0;
        case (req)
            2'b10:   pick = 1'b1;
            2'b11:   pick = ~last;
            default: pick = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Mealy detector step for the bit currently under the index
    // ------------------------------------------------------------------
    assign cur_bit = shreg[idx];

    always_comb begin
        det_nxt = DET_S0;
        hit     = 1'b0;
        case (det)
            DET_S0: det_nxt = cur_bit ? DET_S1 : DET_S0;
            DET_S1: det_nxt = cur_bit ? DET_S2 : DET_S0;
            DET_S2: begin
                if (cur_bit) begin
                    det_nxt = DET_S2;
                end else begin
                    det_nxt = DET_S0;
                    hit     = 1'b1;
                end
            end
            default: det_nxt = DET_S0;
        endcase
    end

    // The last SCAN cycle publishes the map including its own bit, so the
    // result, count and total are all taken from the next-map value.
    always_comb begin
        map_nxt      = map;
        map_nxt[idx] = map[idx] | hit;
    end

    always_comb begin
        cnt_nxt = '0;
        for (int unsigned i = 0; i < W; i++) begin
            cnt_nxt = cnt_nxt + CNT_W'(map_nxt[i]);
        end
    end

    assign tot_sum = {1'b0, total_cnt} + (TOT_W + 1)'(cnt_nxt);

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            sel       <= 1'b0;
            last      <= 1'b1;    // so that requester 0 wins the first tie
            shreg     <= '0;
            map       <= '0;
            det       <= DET_S0;
            idx       <= '0;
            result    <= '0;
            match_cnt <= '0;
            total_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req != 2'b00) begin
                        sel   <= pick;
                        last  <= pick;
                        state <= ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    shreg <= sel ? word1 : word0;
                    det   <= DET_S0;
                    idx   <= IDX_TOP;
                    map   <= '0;
                    state <= ST_SCAN;
                end

                ST_SCAN: begin
                    det <= det_nxt;
                    map <= map_nxt;
                    if (idx == '0) begin
                        result    <= map_nxt;
                        match_cnt <= cnt_nxt;
                        total_cnt <= tot_sum[TOT_W] ? '1 : tot_sum[TOT_W-1:0];
                        state     <= ST_DONE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs decoded from registered state
    // ------------------------------------------------------------------
    assign busy = (state != ST_IDLE);
    assign gnt  = (state == ST_LOAD || state == ST_SCAN) ? {sel, ~sel} : 2'b00;
    assign done = (state == ST_DONE) ? {sel, ~sel} : 2'b00;

endmodule
